// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
// Holds the FSM state encoding, the DYNAMICDELAY field layout and the counter width.
package pll_seq_pkg;

  localparam int CNT_W   = 16;
  localparam int FB_LSB  = 0;
  localparam int REL_LSB = 4;
  localparam int FDA_W   = 4;

  typedef enum logic [2:0] {
    RESET  = 3'd0,
    WAIT   = 3'd1,
    STABLE = 3'd2,
    RUN    = 3'd3,
    FAULT  = 3'd4
  } state_t;

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level (the PLL LOCK pin).
// Latency: two clk edges; no backpressure.
module sync_2ff (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Drives a PLL through reset, lock wait and lock qualification, with retry/bypass on failure.
// Outputs decode from state; delay updates handshake combinationally and land on the accepting edge.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter logic [7:0]  DELAY_INIT   = 8'h00
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  output logic       pll_resetb,
  output logic       pll_bypass,
  output logic [7:0] pll_dynamicdelay,
  input  logic       upd_valid,
  input  logic [7:0] upd_delay,
  output logic       upd_ready,
  input  logic       retry_req,
  output logic       ready,
  output logic       fault,
  output logic       lock_lost,
  output logic [3:0] retries
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [3:0]       MAX_R    = 4'(MAX_RETRIES);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             lock_s;
  logic [3:0]       retries_inc;
  logic             timeout;

  sync_2ff u_lock_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pll_lock),
    .q      (lock_s)
  );

  assign retries_inc = retries + 4'd1;
  assign timeout     = (state == WAIT) && !lock_s && (cnt == TO_LAST);

  assign pll_resetb = (state == WAIT) || (state == STABLE) || (state == RUN);
  assign pll_bypass = (state == FAULT);
  assign fault      = (state == FAULT);
  assign ready      = (state == RUN);
  assign upd_ready  = upd_valid && ((state == RUN) || (state == FAULT));

  always_comb begin
    state_n = state;
    unique case (state)
      RESET:   if (cnt == RST_LAST) state_n = WAIT;
      WAIT: begin
        if (lock_s)       state_n = STABLE;
        else if (timeout) state_n = (retries_inc == MAX_R) ? FAULT : RESET;
      end
      STABLE: begin
        if (!lock_s)               state_n = WAIT;
        else if (cnt == STB_LAST)  state_n = RUN;
      end
      // Lock loss and an update in the same cycle still make a single trip to RESET.
      RUN:     if (!lock_s || upd_valid) state_n = RESET;
      FAULT:   if (retry_req) state_n = RESET;
      default: state_n = RESET;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= RESET;
      cnt              <= '0;
      pll_dynamicdelay <= DELAY_INIT;
      lock_lost        <= 1'b0;
      retries          <= 4'd0;
    end else begin
      state <= state_n;
      if (state_n != state) cnt <= '0;
      else if (cnt != '1)   cnt <= cnt + 1'b1;

      if (upd_ready) pll_dynamicdelay <= upd_delay;

      if ((state == RUN) && !lock_s) lock_lost <= 1'b0 | 1'b1;
      else if (retry_req)            lock_lost <= 1'b0;

      if (timeout && (retries != MAX_R))           retries <= retries_inc;
      else if ((state == STABLE) && (state_n == RUN)) retries <= 4'd0;
      else if ((state == FAULT) && retry_req)     retries <= 4'd0;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with RESET_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pll_lock = 1'b0;
  logic       upd_valid = 1'b0;
  logic [7:0] upd_delay = 8'h00;
  logic       retry_req = 1'b0;
  logic       pll_resetb, pll_bypass, upd_ready, ready, fault, lock_lost;
  logic [7:0] pll_dynamicdelay;
  logic [3:0] retries;

  int vectors = 0;
  int miscompares = 0;

  pll_lock_sequencer #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (20),
    .LOCK_STABLE  (8),
    .MAX_RETRIES  (2),
    .DELAY_INIT   (8'h00)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .pll_lock         (pll_lock),
    .pll_resetb       (pll_resetb),
    .pll_bypass       (pll_bypass),
    .pll_dynamicdelay (pll_dynamicdelay),
    .upd_valid        (upd_valid),
    .upd_delay        (upd_delay),
    .upd_ready        (upd_ready),
    .retry_req        (retry_req),
    .ready            (ready),
    .fault            (fault),
    .lock_lost        (lock_lost),
    .retries          (retries)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_resetb", 32'(pll_resetb), 0);
    chk("rst_bypass", 32'(pll_bypass), 0);
    chk("rst_delay", 32'(pll_dynamicdelay), 32'h00);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_lost", 32'(lock_lost), 0);
    chk("rst_retries", 32'(retries), 0);

    // Nominal lock: RESETB low for edges 1..3, high from edge 4
    resetn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("nom_resetb", 32'(pll_resetb), (k < 4) ? 32'd0 : 32'd1);
    end
    repeat (5) step();
    pll_lock = 1'b1;
    repeat (10) step();
    chk("nom_ready_e19", 32'(ready), 0);
    step();
    chk("nom_ready_e20", 32'(ready), 1);
    chk("nom_retries", 32'(retries), 0);
    chk("nom_resetb_run", 32'(pll_resetb), 1);

    // Delay update in RUN
    upd_valid = 1'b1; upd_delay = 8'hA5;
    #1;
    chk("upd_ready_run", 32'(upd_ready), 1);
    step();
    upd_valid = 1'b0;
    chk("upd_delay_a5", 32'(pll_dynamicdelay), 32'hA5);
    chk("upd_ready_drop", 32'(ready), 0);
    chk("upd_resetb_lo", 32'(pll_resetb), 0);
    repeat (3) step();
    chk("upd_resetb_lo3", 32'(pll_resetb), 0);
    step();
    chk("upd_resetb_hi", 32'(pll_resetb), 1);
    repeat (8) step();
    chk("upd_relock_pre", 32'(ready), 0);
    step();
    chk("upd_relock", 32'(ready), 1);
    chk("upd_no_lost", 32'(lock_lost), 0);

    // Simultaneous lock loss and update
    pll_lock = 1'b0;
    repeat (2) step();
    chk("sim_still_run", 32'(ready), 1);
    upd_valid = 1'b1; upd_delay = 8'h3C;
    #1;
    chk("sim_upd_ready", 32'(upd_ready), 1);
    step();
    upd_valid = 1'b0;
    chk("sim_lost", 32'(lock_lost), 1);
    chk("sim_delay", 32'(pll_dynamicdelay), 32'h3C);
    chk("sim_resetb", 32'(pll_resetb), 0);
    chk("sim_ready", 32'(ready), 0);
    repeat (3) step();
    chk("sim_resetb_lo3", 32'(pll_resetb), 0);
    step();
    chk("sim_one_reset", 32'(pll_resetb), 1);

    // Update stalled during WAIT until RUN
    upd_valid = 1'b1; upd_delay = 8'h77;
    #1;
    chk("stall_wait", 32'(upd_ready), 0);
    repeat (2) step();
    chk("stall_wait2", 32'(upd_ready), 0);
    chk("stall_delay", 32'(pll_dynamicdelay), 32'h3C);
    pll_lock = 1'b1;
    repeat (10) step();
    chk("stall_stable", 32'(upd_ready), 0);
    step();
    chk("stall_run_ready", 32'(ready), 1);
    chk("stall_run_upd", 32'(upd_ready), 1);
    step();
    upd_valid = 1'b0;
    chk("stall_delay77", 32'(pll_dynamicdelay), 32'h77);
    chk("stall_ready0", 32'(ready), 0);
    retry_req = 1'b1;
    step();
    retry_req = 1'b0;
    chk("retry_clr_lost", 32'(lock_lost), 0);

    // Lock glitch mid-STABLE
    repeat (7) step();
    pll_lock = 1'b0;
    repeat (3) step();
    pll_lock = 1'b1;
    chk("gl_ready_a", 32'(ready), 0);
    chk("gl_in_wait", 32'(pll_resetb), 1);
    repeat (2) step();
    chk("gl_ready_b", 32'(ready), 0);
    repeat (8) step();
    chk("gl_ready_c", 32'(ready), 0);
    step();
    chk("gl_ready_d", 32'(ready), 1);

    // Lock loss in RUN, timeouts, FAULT
    pll_lock = 1'b0;
    repeat (3) step();
    chk("to_ready", 32'(ready), 0);
    chk("to_lost", 32'(lock_lost), 1);
    chk("to_retries0", 32'(retries), 0);
    repeat (23) step();
    chk("to_wait_hi", 32'(pll_resetb), 1);
    chk("to_retries0b", 32'(retries), 0);
    step();
    chk("to_retries1", 32'(retries), 1);
    chk("to_resetb1", 32'(pll_resetb), 0);
    chk("to_fault0", 32'(fault), 0);
    repeat (24) step();
    chk("flt_fault", 32'(fault), 1);
    chk("flt_bypass", 32'(pll_bypass), 1);
    chk("flt_retries", 32'(retries), 2);
    chk("flt_resetb", 32'(pll_resetb), 0);
    chk("flt_ready", 32'(ready), 0);
    repeat (3) step();
    chk("flt_hold", 32'(fault), 1);
    chk("flt_sat", 32'(retries), 2);
    upd_valid = 1'b1; upd_delay = 8'h5A;
    #1;
    chk("flt_upd_ready", 32'(upd_ready), 1);
    step();
    upd_valid = 1'b0;
    chk("flt_delay", 32'(pll_dynamicdelay), 32'h5A);
    chk("flt_still", 32'(fault), 1);
    retry_req = 1'b1;
    step();
    retry_req = 1'b0;
    chk("rq_fault", 32'(fault), 0);
    chk("rq_bypass", 32'(pll_bypass), 0);
    chk("rq_retries", 32'(retries), 0);
    chk("rq_lost", 32'(lock_lost), 0);
    chk("rq_resetb", 32'(pll_resetb), 0);
    repeat (3) step();
    chk("rq_resetb3", 32'(pll_resetb), 0);
    step();
    chk("rq_resetb_hi", 32'(pll_resetb), 1);

    // Asynchronous reset mid-WAIT
    repeat (2) step();
    upd_valid = 1'b1;
    #1;
    resetn = 1'b0;
    #1;
    chk("ar_resetb", 32'(pll_resetb), 0);
    chk("ar_delay", 32'(pll_dynamicdelay), 32'h00);
    chk("ar_bypass", 32'(pll_bypass), 0);
    chk("ar_upd_ready", 32'(upd_ready), 0);
    chk("ar_ready", 32'(ready), 0);
    chk("ar_fault", 32'(fault), 0);
    chk("ar_lost", 32'(lock_lost), 0);
    chk("ar_retries", 32'(retries), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Sequences one SB_PLL40_2F_PAD instance through reset, lock acquisition and lock qualification, and retries on lock timeout. Loads runtime feedback/relative fine-delay settings onto DYNAMICDELAY through a valid/ready port, and forces the PLL into bypass after repeated lock failures. Sits between the PLL primitive and system reset logic. `ready` gates release of PLL-clocked logic.

## Interface
Parameters:
- RESET_CYCLES, 16: cycles PLL RESETB is held low per attempt (1..65535).
- LOCK_TIMEOUT, 65535: cycles allowed in WAIT for synchronised lock before an attempt fails (1..65535).
- LOCK_STABLE, 256: consecutive synchronised-lock-high cycles required before `ready` (1..65535).
- MAX_RETRIES, 3: failed attempts before FAULT (1..15).
- DELAY_INIT, 8'h00: DYNAMICDELAY value after reset.

Ports:
- clk  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- pll_lock  in  1  PLL LOCK (asynchronous to clk).
- pll_resetb  out  1  to PLL RESETB.
- pll_bypass  out  1  to PLL BYPASS.
- pll_dynamicdelay  out  8  to PLL DYNAMICDELAY; [3:0] feedback FDA, [7:4] relative FDA.
- upd_valid  in  1  new delay request.
- upd_delay  in  8  requested delay, same packing.
- upd_ready  out  1  update accepted this cycle.
- retry_req  in  1  single-cycle pulse; leave FAULT.
- ready  out  1  PLL locked and qualified.
- fault  out  1  retries exhausted.
- lock_lost  out  1  sticky; set on lock loss in RUN, cleared by retry_req.
- retries  out  4  failed attempts since last RUN entry.

## Operation
- `pll_lock` passes through a 2-flop synchroniser, giving `lock_s`. One 16-bit counter `cnt` is shared by all states and cleared on every state change.
- Reset values: state RESET, cnt 0, pll_resetb 0, pll_bypass 0, pll_dynamicdelay DELAY_INIT, upd_ready 0, ready 0, fault 0, lock_lost 0, retries 0.
- RESET: pll_resetb=0. When cnt==RESET_CYCLES-1, go to WAIT.
- WAIT: pll_resetb=1.
  - lock_s=1: go to STABLE.
  - Else if cnt==LOCK_TIMEOUT-1: retries+1. Go to FAULT if the new value equals MAX_RETRIES, otherwise to RESET.
- STABLE: pll_resetb=1.
  - lock_s=0: return to WAIT; the timeout count restarts.
  - cnt==LOCK_STABLE-1 with lock_s=1: go to RUN and clear retries.
- RUN: ready=1.
  - lock_s=0: set lock_lost and go to RESET; retries unchanged.
  - upd_valid=1: accept (see below) and go to RESET to relock with the new delay.
  - Both in the same cycle: accept the update, set lock_lost, take a single transition to RESET.
- FAULT: fault=1, pll_bypass=1, pll_resetb=0, ready=0.
  - Updates are still accepted and stored; state does not change.
  - retry_req: clear retries, fault and lock_lost, then go to RESET with pll_bypass=0.
- Update handshake: upd_ready is combinational and equals upd_valid && (state==RUN || state==FAULT). On acceptance, pll_dynamicdelay <= upd_delay on the same edge. Requests in other states stall (valid held, ready low).
- retry_req outside FAULT clears only lock_lost.
- Asserting resetn mid-sequence returns all outputs to reset values immediately. pll_resetb=0 is therefore asynchronous to clk.

## Timing
- After resetn deasserts, pll_resetb stays low for exactly RESET_CYCLES rising edges.
- lock_s lags pll_lock by 2 cycles.
- ready rises LOCK_STABLE cycles after the first lock_s high in STABLE. It falls on the edge after lock_s drops, or on update acceptance.
- pll_dynamicdelay changes only on an accepting edge. The following RESET guarantees RESETB is low for at least RESET_CYCLES after any delay change.
- retries saturates at MAX_RETRIES and never wraps.

## Structure
- Package pll_seq_pkg contains:
  - state enum {RESET, WAIT, STABLE, RUN, FAULT};
  - FDA field localparams (FB_LSB=0, REL_LSB=4, FDA_W=4);
  - counter width 16.
- Sub-module sync_2ff, which synchronises pll_lock.

## Test plan
All scenarios use RESET_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2.
- Nominal lock: release resetn, raise pll_lock at cycle 10 -> pll_resetb low for cycles 0-3, ready=1 at cycle 10+2+8, retries=0.
- Timeout then fault: pll_lock held 0 -> two RESET/WAIT attempts, retries 1 then 2, fault=1, pll_bypass=1. A retry_req pulse gives fault=0 and pll_resetb low for 4 cycles.
- Lock glitch in STABLE: drop pll_lock for 3 cycles mid-STABLE -> state returns to WAIT and ready stays 0 until 8 fresh stable cycles.
- Delay update in RUN: upd_valid with upd_delay=8'hA5 -> upd_ready=1 that cycle, pll_dynamicdelay=8'hA5 next cycle, ready=0, RESETB low 4 cycles, then relock.
- Simultaneous lock loss and update in RUN: -> lock_lost=1, delay updated, exactly one RESET entry. An update attempted during WAIT stays stalled (upd_ready=0) until RUN.
- Async reset mid-WAIT: -> all outputs take reset values immediately and pll_dynamicdelay returns to DELAY_INIT.
